// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman host feeder: base encoding, default core
// widths and the feeder state type.
package sw_pkg;

   localparam logic [1:0] BASE_A = 2'd0;
   localparam logic [1:0] BASE_C = 2'd1;
   localparam logic [1:0] BASE_G = 2'd2;
   localparam logic [1:0] BASE_T = 2'd3;

   localparam int unsigned SW_WIDTH_SCORE     = 8;
   localparam int unsigned SW_WIDTH_POS_REF   = 7;
   localparam int unsigned SW_WIDTH_POS_QUERY = 6;

   typedef enum logic [1:0] {
      StIdle,
      StStream,
      StWait,
      StDone
   } feeder_state_e;

endpackage

// File: rtl/sw_seq_feeder_if.sv
// Host/core-facing bundle of the sequence feeder. timeout_err exists only when
// SW_FEEDER_TIMEOUT_EN is defined.
interface sw_seq_feeder_if
   import sw_pkg::*;
#(
   parameter int unsigned WIDTH_SCORE     = SW_WIDTH_SCORE,
   parameter int unsigned WIDTH_POS_REF   = SW_WIDTH_POS_REF,
   parameter int unsigned WIDTH_POS_QUERY = SW_WIDTH_POS_QUERY
) ();

   logic                       wr_en;
   logic                       wr_sel;
   logic [WIDTH_POS_REF-1:0]   wr_addr;
   logic [1:0]                 wr_data;
   logic                       start;
   logic                       busy;
   logic                       sw_valid;
   logic [1:0]                 sw_data_ref;
   logic [1:0]                 sw_data_query;
   logic                       sw_finish;
   logic [WIDTH_SCORE-1:0]     sw_max;
   logic [WIDTH_POS_REF-1:0]   sw_pos_ref;
   logic [WIDTH_POS_QUERY-1:0] sw_pos_query;
   logic                       done;
   logic [WIDTH_SCORE-1:0]     res_max;
   logic [WIDTH_POS_REF-1:0]   res_pos_ref;
   logic [WIDTH_POS_QUERY-1:0] res_pos_query;
`ifdef SW_FEEDER_TIMEOUT_EN
   logic                       timeout_err;
`endif

   // Host and SW core model side.
   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, start, sw_finish, sw_max, sw_pos_ref, sw_pos_query,
      input  busy, sw_valid, sw_data_ref, sw_data_query, done, res_max, res_pos_ref, res_pos_query
`ifdef SW_FEEDER_TIMEOUT_EN
      , timeout_err
`endif
   );

   // Feeder side.
   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, start, sw_finish, sw_max, sw_pos_ref, sw_pos_query,
      output busy, sw_valid, sw_data_ref, sw_data_query, done, res_max, res_pos_ref, res_pos_query
`ifdef SW_FEEDER_TIMEOUT_EN
      , timeout_err
`endif
   );

endinterface

// File: rtl/sw_base_buf.sv
// 2-bit base register file: one synchronous write port, one combinational read port.
// Storage has no reset; out-of-range reads return BASE_A.
module sw_base_buf
   import sw_pkg::*;
#(
   parameter int unsigned Depth = 64,
   parameter int unsigned AddrW = 7
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [1:0]       wdata_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [1:0]       rdata_o
);

   localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [1:0] mem_q [Depth];

   always_ff @(posedge clk_i) begin
      if (we_i && (32'(waddr_i) < Depth)) begin
         mem_q[waddr_i[IdxW-1:0]] <= wdata_i;
      end
   end

   assign rdata_o = (32'(raddr_i) < Depth) ? mem_q[raddr_i[IdxW-1:0]] : BASE_A;

endmodule

// File: rtl/sw_seq_feeder.sv
// Host-side transmitter for the SW scoring core: buffers ref/query bases, streams them, latches
// the result. Define SW_FEEDER_TIMEOUT_EN to add the finish watchdog and timeout_err.
module sw_seq_feeder
   import sw_pkg::*;
#(
   parameter int unsigned WIDTH_SCORE     = SW_WIDTH_SCORE,
   parameter int unsigned WIDTH_POS_REF   = SW_WIDTH_POS_REF,
   parameter int unsigned WIDTH_POS_QUERY = SW_WIDTH_POS_QUERY,
   parameter int unsigned REF_LEN         = 64,
   parameter int unsigned QUERY_LEN       = 48
`ifdef SW_FEEDER_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES  = 1024
`endif
) (
   input logic            clk,
   input logic            reset,
   sw_seq_feeder_if.slave bus
);

   // One extra bit so the counter can reach REF_LEN == 2^WIDTH_POS_REF.
   localparam int unsigned KW = WIDTH_POS_REF + 1;

   feeder_state_e              state_q;
   logic [KW-1:0]              k_q;
   logic                       busy_q;
   logic                       valid_q;
   logic                       done_q;
   logic [1:0]                 data_ref_q;
   logic [1:0]                 data_query_q;
   logic [WIDTH_SCORE-1:0]     res_max_q;
   logic [WIDTH_POS_REF-1:0]   res_pos_ref_q;
   logic [WIDTH_POS_QUERY-1:0] res_pos_query_q;

   logic                     wr_ref;
   logic                     wr_query;
   logic [WIDTH_POS_REF-1:0] rd_idx;
   logic [1:0]               ref_rd;
   logic [1:0]               query_rd;
   logic [1:0]               ref_beat;
   logic [1:0]               query_beat;

`ifdef SW_FEEDER_TIMEOUT_EN
   localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WdW-1:0] wd_q;
   logic           timeout_err_q;
`endif

   // k_q is zero in IDLE, so the first beat reads index 0; a same-cycle write is forwarded.
   always_comb begin
      wr_ref   = (state_q == StIdle) && bus.wr_en && !bus.wr_sel &&
                 (32'(bus.wr_addr) < REF_LEN);
      wr_query = (state_q == StIdle) && bus.wr_en && bus.wr_sel &&
                 (32'(bus.wr_addr) < QUERY_LEN);
      rd_idx   = k_q[WIDTH_POS_REF-1:0];
      ref_beat = (wr_ref && (bus.wr_addr == rd_idx)) ? bus.wr_data : ref_rd;
      query_beat = 2'b00;
      if (32'(k_q) < QUERY_LEN) begin
         query_beat = (wr_query && (bus.wr_addr == rd_idx)) ? bus.wr_data : query_rd;
      end
   end

   sw_base_buf #(
      .Depth(REF_LEN),
      .AddrW(WIDTH_POS_REF)
   ) u_ref_buf (
      .clk_i  (clk),
      .we_i   (wr_ref),
      .waddr_i(bus.wr_addr),
      .wdata_i(bus.wr_data),
      .raddr_i(rd_idx),
      .rdata_o(ref_rd)
   );

   sw_base_buf #(
      .Depth(QUERY_LEN),
      .AddrW(WIDTH_POS_QUERY)
   ) u_query_buf (
      .clk_i  (clk),
      .we_i   (wr_query),
      .waddr_i(bus.wr_addr[WIDTH_POS_QUERY-1:0]),
      .wdata_i(bus.wr_data),
      .raddr_i(rd_idx[WIDTH_POS_QUERY-1:0]),
      .rdata_o(query_rd)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= StIdle;
         k_q             <= '0;
         busy_q          <= 1'b0;
         valid_q         <= 1'b0;
         done_q          <= 1'b0;
         data_ref_q      <= 2'b00;
         data_query_q    <= 2'b00;
         res_max_q       <= '0;
         res_pos_ref_q   <= '0;
         res_pos_query_q <= '0;
`ifdef SW_FEEDER_TIMEOUT_EN
         wd_q            <= '0;
         timeout_err_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  state_q      <= StStream;
                  busy_q       <= 1'b1;
                  valid_q      <= 1'b1;
                  data_ref_q   <= ref_beat;
                  data_query_q <= query_beat;
                  k_q          <= KW'(1);
`ifdef SW_FEEDER_TIMEOUT_EN
                  timeout_err_q <= 1'b0;
`endif
               end
            end
            StStream: begin
               if (32'(k_q) == REF_LEN) begin
                  state_q      <= StWait;
                  valid_q      <= 1'b0;
                  data_ref_q   <= 2'b00;
                  data_query_q <= 2'b00;
                  k_q          <= '0;
`ifdef SW_FEEDER_TIMEOUT_EN
                  wd_q         <= '0;
`endif
               end else begin
                  valid_q      <= 1'b1;
                  data_ref_q   <= ref_beat;
                  data_query_q <= query_beat;
                  k_q          <= k_q + KW'(1);
               end
            end
            StWait: begin
               if (bus.sw_finish) begin
                  res_max_q       <= bus.sw_max;
                  res_pos_ref_q   <= bus.sw_pos_ref;
                  res_pos_query_q <= bus.sw_pos_query;
                  state_q         <= StDone;
                  done_q          <= 1'b1;
                  busy_q          <= 1'b0;
               end
`ifdef SW_FEEDER_TIMEOUT_EN
               else if (32'(wd_q) == TIMEOUT_CYCLES - 1) begin
                  state_q       <= StDone;
                  done_q        <= 1'b1;
                  busy_q        <= 1'b0;
                  timeout_err_q <= 1'b1;
               end else begin
                  wd_q <= wd_q + WdW'(1);
               end
`endif
            end
            StDone: begin
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy          = busy_q;
   assign bus.sw_valid      = valid_q;
   assign bus.sw_data_ref   = data_ref_q;
   assign bus.sw_data_query = data_query_q;
   assign bus.done          = done_q;
   assign bus.res_max       = res_max_q;
   assign bus.res_pos_ref   = res_pos_ref_q;
   assign bus.res_pos_query = res_pos_query_q;
`ifdef SW_FEEDER_TIMEOUT_EN
   assign bus.timeout_err   = timeout_err_q;
`endif

endmodule

// File: tb/tb_sw_seq_feeder.sv
// Self-checking bench for sw_seq_feeder: table of runs plus random runs against a simple
// array model of the two buffers. Covers the watchdog when SW_FEEDER_TIMEOUT_EN is defined.
module tb_sw_seq_feeder;
   import sw_pkg::*;

   localparam int REF_LEN   = 64;
   localparam int QUERY_LEN = 48;
`ifdef SW_FEEDER_TIMEOUT_EN
   localparam int TIMEOUT_CYCLES = 16;
`endif

   logic clk = 1'b0;
   logic reset;

   sw_seq_feeder_if #(
      .WIDTH_SCORE    (8),
      .WIDTH_POS_REF  (7),
      .WIDTH_POS_QUERY(6)
   ) bus ();

   sw_seq_feeder #(
      .WIDTH_SCORE    (8),
      .WIDTH_POS_REF  (7),
      .WIDTH_POS_QUERY(6),
      .REF_LEN        (REF_LEN),
      .QUERY_LEN      (QUERY_LEN)
`ifdef SW_FEEDER_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         delay;
      logic [7:0] mx;
      logic [6:0] pr;
      logic [5:0] pq;
      bit         disturb;
      bit         early;
      bit         wr_at_start;
      int         exp_done;
   } run_vec_t;

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc_g = 0;
   logic [1:0] ref_m [REF_LEN];
   logic [1:0] qry_m [QUERY_LEN];
   logic [7:0] m_max;
   logic [6:0] m_pr;
   logic [5:0] m_pq;
   run_vec_t   vecs [5];

   task automatic tick();
      @(posedge clk);
      #1;
      cyc_g++;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_g);
      end
   endtask

   // Host write; the model applies the acceptance rule from the address range alone.
   task automatic wr(input bit sel, input int a, input logic [1:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_sel  = sel;
      bus.wr_addr = 7'(a);
      bus.wr_data = d;
      tick();
      bus.wr_en = 1'b0;
      if (!sel && a < REF_LEN) ref_m[a] = d;
      else if (sel && a < QUERY_LEN) qry_m[a] = d;
   endtask

   task automatic fill_random();
      for (int i = 0; i < REF_LEN; i++) wr(1'b0, i, 2'($urandom));
      for (int i = 0; i < QUERY_LEN; i++) wr(1'b1, i, 2'($urandom));
      // Out-of-range writes, including aliases of index 0 in the low address bits.
      wr(1'b0, REF_LEN, ~ref_m[0]);
      wr(1'b0, 127, ~ref_m[63]);
      wr(1'b1, 64, ~qry_m[0]);
      wr(1'b1, QUERY_LEN, ~qry_m[0]);
      wr(1'b1, $urandom_range(QUERY_LEN, 127), 2'($urandom));
   endtask

   task automatic do_run(input run_vec_t v);
      logic [1:0] eq;
      logic [1:0] nd;
      int         start_cyc;
      int         done_cyc;
      if (v.wr_at_start) begin
         bus.wr_en = 1'b1;
         bus.wr_addr = 7'd0;
         if ($urandom_range(0, 1) == 1) begin
            nd = ~qry_m[0];
            bus.wr_sel = 1'b1;
            qry_m[0] = nd;
         end else begin
            nd = ~ref_m[0];
            bus.wr_sel = 1'b0;
            ref_m[0] = nd;
         end
         bus.wr_data = nd;
      end
      bus.start = 1'b1;
      start_cyc = cyc_g;
      tick();
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
`ifdef SW_FEEDER_TIMEOUT_EN
      check("tmo_clear_on_start", 64'(bus.timeout_err), 64'd0);
`endif
      for (int b = 0; b < REF_LEN; b++) begin
         eq = (b < QUERY_LEN) ? qry_m[b] : 2'b00;
         check($sformatf("beat%0d", b),
               64'({bus.busy, bus.sw_valid, bus.done, bus.sw_data_ref, bus.sw_data_query}),
               64'({1'b1, 1'b1, 1'b0, ref_m[b], eq}));
         if (v.disturb) begin
            bus.start = (b == 5 || b == 40);
            bus.wr_en = (b >= 8 && b < 14);
            bus.wr_sel = 1'(b & 1);
            bus.wr_addr = 7'(b & 15);
            bus.wr_data = 2'($urandom);
         end
         if (v.early) begin
            bus.sw_finish = (b == 20);
            bus.sw_max = 8'hee;
            bus.sw_pos_ref = 7'h11;
            bus.sw_pos_query = 6'h22;
         end
         tick();
         bus.start = 1'b0;
         bus.wr_en = 1'b0;
         bus.sw_finish = 1'b0;
      end
      check("wait_entry",
            64'({bus.busy, bus.sw_valid, bus.done, bus.sw_data_ref, bus.sw_data_query}),
            64'({1'b1, 1'b0, 1'b0, 2'b00, 2'b00}));
      for (int i = 0; i < v.delay; i++) begin
         tick();
         check("waiting", 64'({bus.busy, bus.sw_valid, bus.done}), 64'(3'b100));
      end
      bus.sw_finish = 1'b1;
      bus.sw_max = v.mx;
      bus.sw_pos_ref = v.pr;
      bus.sw_pos_query = v.pq;
      tick();
      bus.sw_finish = 1'b0;
      bus.sw_max = 8'($urandom);
      bus.sw_pos_ref = 7'($urandom);
      bus.sw_pos_query = 6'($urandom);
      done_cyc = -1;
      for (int i = 0; i < 8; i++) begin
         if (bus.done) begin
            done_cyc = cyc_g - start_cyc;
            break;
         end
         tick();
      end
      check("done_cycle", 64'(done_cyc), 64'(v.exp_done));
      m_max = v.mx;
      m_pr = v.pr;
      m_pq = v.pq;
      check("done_result",
            64'({bus.busy, bus.sw_valid, bus.res_max, bus.res_pos_ref, bus.res_pos_query}),
            64'({1'b0, 1'b0, m_max, m_pr, m_pq}));
`ifdef SW_FEEDER_TIMEOUT_EN
      check("tmo_not_set", 64'(bus.timeout_err), 64'd0);
`endif
      tick();
      check("done_one_cycle",
            64'({bus.done, bus.busy, bus.res_max, bus.res_pos_ref, bus.res_pos_query}),
            64'({1'b0, 1'b0, m_max, m_pr, m_pq}));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      run_vec_t rv;
      bit       seen_done;
      int       n;

      reset = 1'b0;
      bus.wr_en = 1'b0;
      bus.wr_sel = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.start = 1'b0;
      bus.sw_finish = 1'b0;
      bus.sw_max = '0;
      bus.sw_pos_ref = '0;
      bus.sw_pos_query = '0;
      m_max = '0;
      m_pr = '0;
      m_pq = '0;

      vecs[0] = '{10, 8'd37, 7'd50, 6'd40, 1'b0, 1'b0, 1'b0, REF_LEN + 2 + 10};
      vecs[1] = '{0, 8'hff, 7'd127, 6'd63, 1'b1, 1'b0, 1'b1, 66};
      vecs[2] = '{3, 8'h00, 7'd0, 6'd0, 1'b0, 1'b1, 1'b1, 69};
      vecs[3] = '{15, 8'h5a, 7'd1, 6'd47, 1'b1, 1'b1, 1'b1, 81};
      vecs[4] = '{1, 8'h81, 7'd64, 6'd0, 1'b0, 1'b0, 1'b1, 67};

      repeat (3) tick();
      check("reset_state",
            64'({bus.busy, bus.sw_valid, bus.done, bus.sw_data_ref, bus.sw_data_query,
                 bus.res_max, bus.res_pos_ref, bus.res_pos_query}), 64'd0);
`ifdef SW_FEEDER_TIMEOUT_EN
      check("reset_tmo", 64'(bus.timeout_err), 64'd0);
`endif
      reset = 1'b1;
      tick();

      // ACGT repeated reference, all-G query.
      for (int i = 0; i < REF_LEN; i++) wr(1'b0, i, 2'(i % 4));
      for (int i = 0; i < QUERY_LEN; i++) wr(1'b1, i, BASE_G);
      do_run(vecs[0]);

      fill_random();
      for (int i = 1; i < 5; i++) do_run(vecs[i]);

      // Reset in the middle of a stream aborts it without a done pulse.
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (20) tick();
      check("pre_reset_beat20",
            64'({bus.busy, bus.sw_valid, bus.sw_data_ref, bus.sw_data_query}),
            64'({1'b1, 1'b1, ref_m[20], qry_m[20]}));
      reset = 1'b0;
      tick();
      reset = 1'b1;
      m_max = '0;
      m_pr = '0;
      m_pq = '0;
      check("reset_abort",
            64'({bus.busy, bus.sw_valid, bus.done, bus.sw_data_ref, bus.sw_data_query,
                 bus.res_max, bus.res_pos_ref, bus.res_pos_query}), 64'd0);
      seen_done = 1'b0;
      for (int i = 0; i < 80; i++) begin
         bus.sw_finish = (i == 60);
         bus.sw_max = 8'h77;
         tick();
         seen_done |= bus.done;
      end
      bus.sw_finish = 1'b0;
      check("no_done_after_abort", 64'({seen_done, bus.res_max}), 64'd0);
      rv = '{2, 8'd9, 7'd9, 6'd9, 1'b0, 1'b0, 1'b0, REF_LEN + 2 + 2};
      do_run(rv);

      for (int r = 0; r < 4; r++) begin
         if (r == 2) fill_random();
         rv.delay = $urandom_range(0, 14);
         rv.mx = 8'($urandom);
         rv.pr = 7'($urandom);
         rv.pq = 6'($urandom);
         rv.disturb = 1'($urandom_range(0, 1));
         rv.early = 1'($urandom_range(0, 1));
         rv.wr_at_start = 1'b1;
         rv.exp_done = REF_LEN + 2 + rv.delay;
         do_run(rv);
      end

`ifdef SW_FEEDER_TIMEOUT_EN
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (REF_LEN) tick();
      n = 0;
      while (!bus.done && n < 64) begin
         tick();
         n++;
      end
      check("tmo_latency", 64'(n), 64'(TIMEOUT_CYCLES));
      check("tmo_result",
            64'({bus.timeout_err, bus.busy, bus.res_max, bus.res_pos_ref, bus.res_pos_query}),
            64'({1'b1, 1'b0, m_max, m_pr, m_pq}));
      tick();
      check("tmo_hold", 64'({bus.timeout_err, bus.done}), 64'(2'b10));
      rv = '{4, 8'd200, 7'd3, 6'd5, 1'b0, 1'b0, 1'b1, REF_LEN + 2 + 4};
      do_run(rv);
`else
      n = 0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sw_seq_feeder.md
Name: sw_seq_feeder

Overview:
- Host-side transmitter for the Smith-Waterman (SW) scoring core.
- Buffers one reference sequence and one query sequence of 2-bit bases, written by the host.
- On start, streams both sequences into the SW core using its valid/data_ref/data_query protocol.
- Waits for the core's finish, latches max/pos_ref/pos_query, and reports done to the host.

Parameters:
WIDTH_SCORE, 8, width of SW max score
WIDTH_POS_REF, 7, width of reference position/address
WIDTH_POS_QUERY, 6, width of query position/address
REF_LEN, 64, reference bases streamed per run (1..2^WIDTH_POS_REF)
QUERY_LEN, 48, query bases streamed per run (1..min(REF_LEN, 2^WIDTH_POS_QUERY))
TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
wr_en  in  1  host base write strobe
wr_sel  in  1  0 = reference buffer, 1 = query buffer
wr_addr  in  WIDTH_POS_REF  base index (query buffer uses the low WIDTH_POS_QUERY bits)
wr_data  in  2  base: A=0, C=1, G=2, T=3
start  in  1  single-cycle run request
busy  out  1  high from accepted start until done
sw_valid  out  1  to SW core valid
sw_data_ref  out  2  to SW core data_ref
sw_data_query  out  2  to SW core data_query
sw_finish  in  1  from SW core finish
sw_max  in  WIDTH_SCORE  from SW core max
sw_pos_ref  in  WIDTH_POS_REF  from SW core pos_ref
sw_pos_query  in  WIDTH_POS_QUERY  from SW core pos_query
done  out  1  one-cycle pulse when results are valid
res_max  out  WIDTH_SCORE  latched score
res_pos_ref  out  WIDTH_POS_REF  latched reference position
res_pos_query  out  WIDTH_POS_QUERY  latched query position

Behaviour:
- Reset (reset==0 at a clock edge):
  - State = IDLE; beat counter = 0.
  - busy, sw_valid, done = 0; sw_data_ref, sw_data_query = 0; res_* = 0.
  - Buffer contents are not reset and are retained.
  - Reset asserted in any state aborts the run at that edge; no done pulse is produced.
- Writes:
  - Accepted only in IDLE with wr_en=1.
  - Ignored when busy, or when wr_addr >= REF_LEN (wr_sel=0) or wr_addr >= QUERY_LEN (wr_sel=1).
  - A write and a start in the same IDLE cycle: the write lands first, so the run uses the new value.
- IDLE:
  - start=1 -> STREAM, busy=1, beat counter k=0.
  - start in any other state is ignored.
- STREAM: registered outputs, so the first beat appears in the cycle after start is sampled.
  - Each cycle: sw_valid=1, sw_data_ref=ref[k].
  - sw_data_query = query[k] for k<QUERY_LEN, else 2'b00.
  - k increments each cycle. Exactly REF_LEN consecutive valid beats, with no gaps.
  - After beat REF_LEN-1 -> WAIT; sw_valid=0 and data outputs=0 on the following cycle.
- WAIT:
  - Hold sw_valid=0.
  - When sw_finish=1 is sampled: latch sw_max, sw_pos_ref, sw_pos_query into res_*, then -> DONE.
  - sw_finish during STREAM or IDLE is ignored.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, -> IDLE.
- res_* hold their value until the next capture or reset.
- Minimum run, start to done: REF_LEN + 2 cycles plus core latency.

Optional Feature:
SW_FEEDER_TIMEOUT_EN
- Defined:
  - Adds a watchdog counter, cleared on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES with no sw_finish: go to DONE with done=1 and res_* unchanged.
  - Adds output timeout_err (1 bit): set on timeout, cleared on the next accepted start or on reset.
  - sw_finish in the same cycle the count expires counts as finish, not timeout.
- Undefined: no counter and no timeout_err port; WAIT holds indefinitely.

Decomposition:
- Package sw_pkg holds:
  - base encoding constants (BASE_A/C/G/T)
  - default width constants matching the SW core
  - the feeder state enum (IDLE, STREAM, WAIT, DONE)
- One natural sub-module, sw_base_buf: a parameterised-depth 2-bit register file with one write port and one combinational read port. It is instantiated twice, once with depth REF_LEN and once with depth QUERY_LEN.

Test Plan:
- Reference written ACGT repeated (64 bases), query all G (48 bases), start -> 64 contiguous valid beats; beats 0-3 ref = 0,1,2,3; query = 2 on beats 0-47 and 0 on beats 48-63; valid low on cycle 65.
- Core model asserts finish 10 cycles after last beat with max=8'd37, pos_ref=7'd50, pos_query=6'd40 -> done pulses once; res_* = 37/50/40; busy falls with done.
- start pulsed again mid-STREAM, and wr_en writes during STREAM -> stream unchanged; buffer contents unchanged after the run.
- reset driven low at beat 20 -> next cycle sw_valid=0, state IDLE, no done; a rerun without rewriting the buffers streams the original data.
- finish pulsed during STREAM, then real finish in WAIT -> only the WAIT finish is captured.
- With SW_FEEDER_TIMEOUT_EN and TIMEOUT_CYCLES=16, no finish -> done and timeout_err=1 exactly 16 cycles after WAIT entry; the next start clears timeout_err.
